// File: rtl/riscv_pkg.sv
// Purpose : shared RV32I encoding constants, loader FSM states, immediate range helper.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package riscv_pkg;

   // Instruction format selector codes; 6 and 7 are reserved.
   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_OPIMM  = 7'h13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } enc_state_e;

   // True when v is representable as an n-bit two's-complement value:
   // everything from bit n-1 upward must be a copy of the sign.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
      logic [31:0] hi;
      hi = 32'($signed(v) >>> (n - 1));
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Purpose : field-set input stream, encoded-word output stream and burst control of the loader.
// Latency : n/a (wiring only).
// Backpressure : in_valid/in_ready on the field side, out_valid/out_ready on the memory side.
// Ports   : master = program/bench side, slave = encoder/loader side.
interface inst_encoder_loader_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W:0]   count;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [6:0]        in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;
   logic              out_imm_err;
   logic              busy;
   logic              done;

   modport master (
      output start, count, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_imm_err, busy, done
   );

   modport slave (
      input  start, count, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_imm_err, busy, done
   );
endinterface

// File: rtl/inst_field_packer.sv
// Purpose : pack decoded RV32I fields into one instruction word and flag unencodable immediates.
// Latency : purely combinational, zero cycles.
// Backpressure : none; no state.
// Ports   : fmt/opcode/rd/rs1/rs2/funct3/funct7/imm in; inst, imm_err out.
module inst_field_packer
   import riscv_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        imm_err
);

   always_comb begin
      inst    = '0;
      imm_err = 1'b0;
      case (fmt)
         FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            inst    = {imm[11:0], rs1, funct3, rd, opcode};
            imm_err = !fits_signed(imm, 12);
         end
         FMT_S: begin
            inst    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            imm_err = !fits_signed(imm, 12);
         end
         FMT_B: begin
            // Branch offsets are halfword aligned, so bit 0 is never encoded.
            inst    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            imm_err = !fits_signed(imm, 13) || imm[0];
         end
         FMT_U: begin
            // Low 12 bits cannot be represented; a nonzero value would be silently lost.
            inst    = {imm[31:12], rd, opcode};
            imm_err = (imm[11:0] != 12'd0);
         end
         FMT_J: begin
            inst    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            imm_err = !fits_signed(imm, 21) || imm[0];
         end
         default: begin
            inst    = '0;
            imm_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder_loader.sv
// Purpose : encode a burst of COUNT field sets into RV32I words tagged with word addresses.
// Latency : field set accepted at edge N appears on out_* after edge N; 1 word/cycle sustained.
// Backpressure : single output slot; in_ready drops while the slot is full and out_ready is low.
// Ports   : clk, rst (sync, active high); bus = slave side of inst_encoder_loader_if.
module inst_encoder_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   inst_encoder_loader_if.slave  bus
);

   enc_state_e        state, state_nxt;
   logic [ADDR_W:0]   cnt;        // burst length latched on start
   logic [ADDR_W:0]   accepted;   // field sets taken in
   logic [ADDR_W:0]   emitted;    // words handshaked out
   logic              vld_q;
   logic [31:0]       inst_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;
   logic [31:0]       pk_inst;
   logic              pk_err;
   logic              accept;
   logic              out_hs;
   logic              last_hs;

   inst_field_packer u_packer (
      .fmt     (bus.in_fmt),
      .opcode  (bus.in_opcode),
      .rd      (bus.in_rd),
      .rs1     (bus.in_rs1),
      .rs2     (bus.in_rs2),
      .funct3  (bus.in_funct3),
      .funct7  (bus.in_funct7),
      .imm     (bus.in_imm),
      .inst    (pk_inst),
      .imm_err (pk_err)
   );

   // Slot can be refilled in the same cycle it drains, giving full throughput.
   assign bus.in_ready    = (state == ST_RUN) && (accepted < cnt) && (!vld_q || bus.out_ready);
   assign accept          = bus.in_valid && bus.in_ready;
   assign out_hs          = vld_q && bus.out_ready;
   assign last_hs         = out_hs && ((emitted + 1'b1) == cnt);

   assign bus.out_valid   = vld_q;
   assign bus.out_inst    = inst_q;
   assign bus.out_addr    = addr_q;
   assign bus.out_imm_err = err_q;
   assign bus.busy        = (state == ST_RUN);
   assign bus.done        = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = (bus.count == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (last_hs)   state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         accepted <= '0;
         emitted  <= '0;
         vld_q    <= 1'b0;
         inst_q   <= '0;
         addr_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && bus.start) begin
            cnt      <= bus.count;
            accepted <= '0;
            emitted  <= '0;
            addr_q   <= ADDR_W'(BASE_ADDR);
         end
         if (accept) begin
            vld_q    <= 1'b1;
            inst_q   <= pk_inst;
            err_q    <= pk_err;
            accepted <= accepted + 1'b1;
         end else if (out_hs) begin
            vld_q    <= 1'b0;
         end
         // Address wraps modulo 2^ADDR_W by natural overflow.
         if (out_hs) begin
            emitted <= emitted + 1'b1;
            addr_q  <= addr_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Purpose : directed self-check of encoding, range flags, burst flow, backpressure, wrap and reset.
// Latency : n/a.
// Backpressure : bench drives out_ready always-on, random, or stalled.
module tb_inst_encoder_loader;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  count;
   logic        in_valid;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   inst_encoder_loader_if #(.ADDR_W(8)) bus  ();
   inst_encoder_loader_if #(.ADDR_W(2)) bus2 ();

   assign bus.start      = start;       assign bus2.start     = start;
   assign bus.count      = count;       assign bus2.count     = count[2:0];
   assign bus.in_valid   = in_valid;    assign bus2.in_valid  = in_valid;
   assign bus.in_fmt     = in_fmt;      assign bus2.in_fmt    = in_fmt;
   assign bus.in_opcode  = in_opcode;   assign bus2.in_opcode = in_opcode;
   assign bus.in_rd      = in_rd;       assign bus2.in_rd     = in_rd;
   assign bus.in_rs1     = in_rs1;      assign bus2.in_rs1    = in_rs1;
   assign bus.in_rs2     = in_rs2;      assign bus2.in_rs2    = in_rs2;
   assign bus.in_funct3  = in_funct3;   assign bus2.in_funct3 = in_funct3;
   assign bus.in_funct7  = in_funct7;   assign bus2.in_funct7 = in_funct7;
   assign bus.in_imm     = in_imm;      assign bus2.in_imm    = in_imm;
   assign bus.out_ready  = out_ready;   assign bus2.out_ready = out_ready;

   inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk (clk), .rst (rst), .bus (bus.slave)
   );
   inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2.slave)
   );

   // Vector table: fields plus hand-computed word and error flag.
   logic [2:0]  v_fmt [16];
   logic [6:0]  v_op  [16];
   logic [4:0]  v_rd  [16], v_rs1 [16], v_rs2 [16];
   logic [2:0]  v_f3  [16];
   logic [6:0]  v_f7  [16];
   logic [31:0] v_imm [16], v_exp [16];
   logic        v_err [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic setv(input int i, input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] e,
                       input logic er);
      v_fmt[i] = f; v_op[i] = op; v_rd[i] = rd; v_rs1[i] = r1; v_rs2[i] = r2;
      v_f3[i] = f3; v_f7[i] = f7; v_imm[i] = imm; v_exp[i] = e; v_err[i] = er;
   endtask

   task automatic drive(input int i);
      in_fmt = v_fmt[i]; in_opcode = v_op[i]; in_rd = v_rd[i]; in_rs1 = v_rs1[i];
      in_rs2 = v_rs2[i]; in_funct3 = v_f3[i]; in_funct7 = v_f7[i]; in_imm = v_imm[i];
   endtask

   // mode 0: out_ready=1, mode 1: random 50%, mode 2: stall 5 cycles on first word.
   task automatic burst(input int base, input int n, input int mode, input bit c2);
      int sent, recv, stall;
      bit acc, hs, first, stalled;
      logic [31:0] s_inst, o_inst;
      logic [7:0]  s_addr, o_addr;
      logic [1:0]  o_addr2;
      logic        s_err, o_err;
      sent = 0; recv = 0; stall = 5; first = 1'b1;
      s_inst = '0; s_addr = '0; s_err = 1'b0;
      o_inst = '0; o_addr = '0; o_addr2 = '0; o_err = 1'b0;
      start = 1'b1; count = n[8:0];
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         chk("done_cnt0", {31'd0, bus.done}, 32'd1);
         chk("busy_cnt0", {31'd0, bus.busy}, 32'd0);
         @(posedge clk); #1;
         chk("done_clr_cnt0", {31'd0, bus.done}, 32'd0);
         return;
      end
      chk("busy_run", {31'd0, bus.busy}, 32'd1);
      for (int cyc = 0; cyc < 400 && recv < n; cyc++) begin
         in_valid = (sent < n);
         drive(base + ((sent < n) ? sent : 0));
         stalled = 1'b0;
         if (mode == 2 && bus.out_valid && stall > 0) begin
            out_ready = 1'b0; stalled = 1'b1;
            if (stall == 5) begin
               s_inst = bus.out_inst; s_addr = bus.out_addr; s_err = bus.out_imm_err;
            end
            stall--;
         end else begin
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         #1;
         if (stalled) begin
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            if (stall < 4) begin
               chk("bp_inst", bus.out_inst, s_inst);
               chk("bp_addr", {24'd0, bus.out_addr}, {24'd0, s_addr});
               chk("bp_err", {31'd0, bus.out_imm_err}, {31'd0, s_err});
            end
         end
         acc = in_valid && bus.in_ready;
         hs  = bus.out_valid && out_ready;
         if (hs) begin
            o_inst = bus.out_inst; o_addr = bus.out_addr; o_err = bus.out_imm_err;
            o_addr2 = bus2.out_addr;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (first) chk("latency_valid", {31'd0, bus.out_valid}, 32'd1);
            first = 1'b0;
            sent++;
            if (sent == n) chk("in_ready_after_last", {31'd0, bus.in_ready}, 32'd0);
         end
         if (hs) begin
            chk($sformatf("inst[%0d]", base + recv), o_inst, v_exp[base + recv]);
            chk($sformatf("err[%0d]", base + recv), {31'd0, o_err}, {31'd0, v_err[base + recv]});
            chk($sformatf("addr[%0d]", recv), {24'd0, o_addr}, recv);
            if (c2) chk($sformatf("addr_w2[%0d]", recv), {30'd0, o_addr2}, recv % 4);
            recv++;
            if (recv == n) begin
               chk("done_pulse", {31'd0, bus.done}, 32'd1);
               chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
               in_valid = 1'b0; out_ready = 1'b1;
               @(posedge clk); #1;
               chk("done_clr", {31'd0, bus.done}, 32'd0);
            end
         end
      end
      if (recv < n) chk("burst_timeout", recv, n);
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      setv(0,  FMT_I, OP_LOAD,   5, 2, 0, 3'd2, 7'd0, 32'd8,          32'h00812283, 1'b0);
      setv(1,  FMT_S, OP_STORE,  0, 1, 6, 3'd2, 7'd0, -32'sd4,        32'hFE60AE23, 1'b0);
      setv(2,  FMT_B, OP_BRANCH, 0, 1, 2, 3'd0, 7'd0, -32'sd8,        32'hFE208CE3, 1'b0);
      setv(3,  FMT_R, OP_OP,     3, 1, 2, 3'd0, 7'd0, 32'd0,          32'h002081B3, 1'b0);
      setv(4,  FMT_U, OP_LUI,    1, 0, 0, 3'd0, 7'd0, 32'h12345000,   32'h123450B7, 1'b0);
      setv(5,  FMT_J, OP_JAL,    1, 0, 0, 3'd0, 7'd0, 32'd2048,       32'h001000EF, 1'b0);
      setv(6,  FMT_J, OP_JAL,    1, 0, 0, 3'd0, 7'd0, -32'sd2,        32'hFFFFF0EF, 1'b0);
      setv(7,  FMT_I, OP_OPIMM,  0, 0, 0, 3'd0, 7'd0, 32'd2048,       32'h80000013, 1'b1);
      setv(8,  FMT_I, OP_OPIMM,  0, 0, 0, 3'd0, 7'd0, -32'sd2048,     32'h80000013, 1'b0);
      setv(9,  FMT_B, OP_BRANCH, 0, 0, 0, 3'd0, 7'd0, 32'd6,          32'h00000363, 1'b0);
      setv(10, FMT_B, OP_BRANCH, 0, 0, 0, 3'd0, 7'd0, 32'd7,          32'h00000363, 1'b1);
      setv(11, 3'd6,  OP_OPIMM,  1, 1, 1, 3'd1, 7'd1, 32'd1,          32'h00000000, 1'b1);
      setv(12, FMT_U, OP_LUI,    1, 0, 0, 3'd0, 7'd0, 32'h12345001,   32'h123450B7, 1'b1);
      setv(13, FMT_I, OP_OPIMM,  0, 0, 0, 3'd0, 7'd0, 32'd2047,       32'h7FF00013, 1'b0);
      setv(14, 3'd7,  OP_OP,     2, 2, 2, 3'd0, 7'd0, 32'd0,          32'h00000000, 1'b1);
      setv(15, FMT_J, OP_JAL,    0, 0, 0, 3'd0, 7'd0, 32'd1,          32'h0000006F, 1'b1);

      rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; out_ready = 1'b1;
      drive(0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_inst", bus.out_inst, 32'd0);
      chk("rst_out_addr", {24'd0, bus.out_addr}, 32'd0);
      chk("rst_out_err", {31'd0, bus.out_imm_err}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      rst = 1'b0;

      // in_valid while IDLE must not be taken.
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("idle_no_valid", {31'd0, bus.out_valid}, 32'd0);
      in_valid = 1'b0;

      burst(0, 16, 0, 1'b0);   // every encoding and range case, full throughput
      burst(0, 4, 1, 1'b0);    // random memory-side backpressure
      burst(0, 0, 0, 1'b0);    // empty burst
      burst(1, 3, 2, 1'b0);    // 5-cycle stall on the first word
      burst(0, 6, 0, 1'b1);    // address wrap on the 2-bit instance

      // Reset in the middle of a burst with a word pending.
      start = 1'b1; count = 9'd4;
      @(posedge clk); #1;
      start = 1'b0;
      drive(0); in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("mid_rst_inst", bus.out_inst, 32'd0);
      chk("mid_rst_addr", {24'd0, bus.out_addr}, 32'd0);
      rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      burst(2, 2, 0, 1'b0);    // restart after abort

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
